// File: rtl/da_drive_pkg.sv
// Shared types and default sizing for the DA drive path.
package da_drive_pkg;

  localparam int CNT_W_DEF     = 9;
  localparam int CNT_LIMIT_DEF = 255;
  localparam int PULSE_W_DEF   = 4;
  localparam int GAP_W_DEF     = 4;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} driveState_e;

endpackage

// File: rtl/drive_pulse_shaper.sv
// Turns one req/ack handshake into a fixed-width ApPGH/AmPGH pulse followed by a fixed low gap.
module drive_pulse_shaper
  import da_drive_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic sign,
  output logic ack,
  output logic ApPGH,
  output logic AmPGH
);

  localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TW   = $clog2(TMAX + 1);

  driveState_e   state, stateNext;
  logic [TW-1:0] tmr, tmrNext;
  logic          apNext, amNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      ApPGH <= 1'b0;
      AmPGH <= 1'b0;
    end else begin
      state <= stateNext;
      tmr   <= tmrNext;
      ApPGH <= apNext;
      AmPGH <= amNext;
    end
  end

  // Outputs are registered, so ack in IDLE lines up with the first high cycle.
  always_comb begin
    stateNext = state;
    tmrNext   = tmr;
    apNext    = ApPGH;
    amNext    = AmPGH;
    ack       = 1'b0;
    if (clr) begin
      stateNext = IDLE;
      tmrNext   = '0;
      apNext    = 1'b0;
      amNext    = 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          ack       = 1'b1;
          stateNext = HIGH;
          tmrNext   = TW'(PULSE_W - 1);
          apNext    = sign;
          amNext    = ~sign;
        end
        HIGH: if (tmr == '0) begin
          stateNext = GAP;
          tmrNext   = TW'(GAP_W - 1);
          apNext    = 1'b0;
          amNext    = 1'b0;
        end else begin
          tmrNext = tmr - 1'b1;
        end
        GAP: if (tmr == '0) stateNext = IDLE;
             else           tmrNext   = tmr - 1'b1;
        default: begin
          stateNext = IDLE;
          apNext    = 1'b0;
          amNext    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/error_counter_drive.sv
// AGC drive strobes -> saturating error count plus backlog of unsent steps -> paced D/A pulses.
module error_counter_drive
  import da_drive_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CNT_LIMIT = CNT_LIMIT_DEF,
  parameter int PULSE_W   = PULSE_W_DEF,
  parameter int GAP_W     = GAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ece,
  input  logic                    drv_p,
  input  logic                    drv_m,
  output logic                    ApPGH,
  output logic                    AmPGH,
  output logic signed [CNT_W-1:0] err_cnt,
  output logic signed [CNT_W-1:0] backlog,
  output logic                    sat
);

  // Backlog can swing to +/-2*CNT_LIMIT, so it is kept one bit wider than the port.
  localparam int BL_W = CNT_W + 1;

  localparam logic signed [CNT_W-1:0] LIM_P     = CNT_W'(CNT_LIMIT);
  localparam logic signed [CNT_W-1:0] LIM_M     = -LIM_P;
  localparam logic signed [CNT_W-1:0] OUT_MAX   = CNT_W'(2**(CNT_W-1) - 1);
  localparam logic signed [BL_W-1:0]  OUT_MAX_W = BL_W'(2**(CNT_W-1) - 1);

  logic signed [BL_W-1:0]  blReg, blNext, dIn, dOut;
  logic signed [CNT_W-1:0] errNext;
  logic                    accP, accM, req, sign, ack;

  assign accP = ece & drv_p & ~drv_m & (err_cnt != LIM_P);
  assign accM = ece & drv_m & ~drv_p & (err_cnt != LIM_M);
  assign req  = ece & (blReg != '0);
  assign sign = ~blReg[BL_W-1];

  always_comb begin
    errNext = err_cnt;
    dIn     = '0;
    dOut    = '0;
    if (accP) begin
      errNext = err_cnt + 1'b1;
      dIn     = BL_W'(1);
    end else if (accM) begin
      errNext = err_cnt - 1'b1;
      dIn     = '1;
    end
    if (ack) dOut = sign ? BL_W'(1) : '1;
    blNext = blReg + dIn - dOut;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      blReg   <= '0;
      sat     <= 1'b0;
    end else if (!ece) begin
      err_cnt <= '0;
      blReg   <= '0;
      sat     <= 1'b0;
    end else begin
      err_cnt <= errNext;
      blReg   <= blNext;
      sat     <= (errNext == LIM_P) || (errNext == LIM_M);
    end
  end

  always_comb begin
    backlog = blReg[CNT_W-1:0];
    if (blReg > OUT_MAX_W)       backlog = OUT_MAX;
    else if (blReg < -OUT_MAX_W) backlog = -OUT_MAX;
  end

  drive_pulse_shaper #(
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W)
  ) uShaper (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (~ece),
    .req  (req),
    .sign (sign),
    .ack  (ack),
    .ApPGH(ApPGH),
    .AmPGH(AmPGH)
  );

endmodule

// File: tb/tb_error_counter_drive.sv
// Scoreboard bench for error_counter_drive: stimulus queues expected pulses, a monitor checks them.
module tb_error_counter_drive;

  localparam int PW  = 4;
  localparam int GW  = 4;
  localparam int LIM = 255;

  logic clk = 1'b0, rst_n = 1'b0, ece = 1'b0, drv_p = 1'b0, drv_m = 1'b0;
  logic ApPGH, AmPGH, sat;
  logic signed [8:0] err_cnt, backlog;

  error_counter_drive dut (
    .clk(clk), .rst_n(rst_n), .ece(ece), .drv_p(drv_p), .drv_m(drv_m),
    .ApPGH(ApPGH), .AmPGH(AmPGH), .err_cnt(err_cnt), .backlog(backlog), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit sgn;
    int rise;
    int width;
  } exp_t;
  exp_t expQ[$];

  int passCnt = 0, totCnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    totCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Pulse monitor: measures rise cycle, sign and width of every pulse.
  bit inPulse = 0, pSgn = 0, pFlip = 0;
  int pRise = 0, pWidth = 0;
  always @(negedge clk) begin
    if (ApPGH || AmPGH) begin
      chk("overlap", int'(ApPGH & AmPGH), 0);
      if (!inPulse) begin
        inPulse = 1; pSgn = ApPGH; pRise = cyc; pWidth = 1; pFlip = 0;
      end else begin
        pWidth++;
        if (ApPGH != pSgn) pFlip = 1;
      end
    end else if (inPulse) begin
      inPulse = 0;
      chk("pulse_sign_steady", int'(pFlip), 0);
      if (expQ.size() == 0) begin
        chk("unexpected_pulse_rise", pRise, -1);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("pulse_sign", int'(pSgn), int'(e.sgn));
        chk("pulse_rise", pRise, e.rise);
        chk("pulse_width", pWidth, e.width);
      end
    end
  end

  task automatic strobe(input bit p, input bit m, output int sc);
    @(posedge clk); #1;
    drv_p = p; drv_m = m; sc = cyc;
    @(posedge clk); #1;
    drv_p = 0; drv_m = 0;
  endtask

  task automatic drain(input int maxC);
    int n = 0;
    while ((expQ.size() != 0 || inPulse) && n < maxC) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", expQ.size(), 0);
    repeat (PW + GW + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, s;
    ece = 1;
    #12;
    chk("rst_ApPGH", ApPGH, 0);
    chk("rst_AmPGH", AmPGH, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_backlog", backlog, 0);
    chk("rst_sat", sat, 0);
    @(negedge clk) rst_n = 1;

    // single plus strobe
    strobe(1, 0, sc);
    expQ.push_back('{1'b1, sc + 2, PW});
    chk("t1_err", err_cnt, 1);
    chk("t1_backlog_pend", backlog, 1);
    @(posedge clk); #1;
    chk("t1_backlog_sent", backlog, 0);
    drain(200);

    // three back-to-back minus strobes -> period PW+GW+1
    @(posedge clk); #1;
    s = cyc; drv_m = 1;
    for (int k = 0; k < 3; k++) expQ.push_back('{1'b0, s + 2 + k * (PW + GW + 1), PW});
    repeat (3) @(posedge clk);
    #1 drv_m = 0;
    chk("t2_err", err_cnt, -2);
    drain(300);
    chk("t2_backlog", backlog, 0);
    chk("t2_err_end", err_cnt, -2);

    // simultaneous strobes cancel
    strobe(1, 1, sc);
    chk("t3_err", err_cnt, -2);
    chk("t3_backlog", backlog, 0);
    drain(50);

    // backlog +2 mid-pulse, then two minus strobes cancel it
    @(posedge clk); #1;
    s = cyc; drv_p = 1;
    expQ.push_back('{1'b1, s + 2, PW});
    repeat (3) @(posedge clk);
    #1;
    chk("t4_backlog_mid", backlog, 2);
    chk("t4_ApPGH_mid", ApPGH, 1);
    drv_p = 0; drv_m = 1;
    repeat (2) @(posedge clk);
    #1 drv_m = 0;
    chk("t4_backlog_end", backlog, 0);
    chk("t4_err", err_cnt, -1);
    drain(200);

    // ece dropped during a minus pulse
    @(posedge clk); #1;
    s = cyc; drv_m = 1;
    expQ.push_back('{1'b0, s + 2, 2});
    repeat (2) @(posedge clk);
    #1 drv_m = 0;
    chk("t5_backlog_mid", backlog, -1);
    chk("t5_err_mid", err_cnt, -3);
    @(posedge clk); #1;
    ece = 0;
    @(posedge clk); #1;
    chk("t5_AmPGH_off", AmPGH, 0);
    chk("t5_err_clr", err_cnt, 0);
    chk("t5_backlog_clr", backlog, 0);
    strobe(1, 0, sc);
    chk("t5_ignored_err", err_cnt, 0);
    ece = 1;
    drain(100);

    // saturate at +LIM, drop one more plus, then step back with one minus
    @(posedge clk); #1;
    s = cyc; drv_p = 1;
    for (int k = 0; k < LIM; k++) expQ.push_back('{1'b1, s + 2 + k * (PW + GW + 1), PW});
    repeat (LIM) @(posedge clk);
    #1 drv_p = 0;
    chk("t6_err_sat", err_cnt, LIM);
    chk("t6_sat", sat, 1);
    drain(3000);
    strobe(1, 0, sc);
    chk("t6_drop_err", err_cnt, LIM);
    chk("t6_drop_sat", sat, 1);
    chk("t6_drop_backlog", backlog, 0);
    drain(50);
    strobe(0, 1, sc);
    expQ.push_back('{1'b0, sc + 2, PW});
    chk("t6_unsat_err", err_cnt, LIM - 1);
    chk("t6_unsat_sat", sat, 0);
    chk("t6_unsat_backlog", backlog, -1);
    drain(100);

    // async reset mid-pulse
    strobe(1, 0, sc);
    expQ.push_back('{1'b1, sc + 2, 1});
    chk("t7_err_pre", err_cnt, LIM);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t7_ApPGH_rst", ApPGH, 0);
    chk("t7_err_rst", err_cnt, 0);
    chk("t7_sat_rst", sat, 0);
    chk("t7_backlog_rst", backlog, 0);
    @(negedge clk) rst_n = 1;
    drain(50);

    chk("final_queue", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
